stb_sched: RTL and testbench

- Round-robin scheduler that shares one burst-store engine (single-issue, no ready, accepts a command only while idle) between REQ_COUNT store-microinstruction requesters.
- Accepts one command, issues it to the engine as a single-cycle stb_u_valid pulse, waits for stb_d_valid, then returns a one-hot completion to the owner.
- Rejects illegal zero-length bursts without issuing them.
- A watchdog detects a hung engine and halts the scheduler.

---
 rtl/stb_sched_if.sv | 58 +++++
 rtl/stb_sched.sv | 200 ++++++++++++++++++++
 tb/tb_stb_sched.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stb_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : stb_sched_if
// Description : Requester, burst-store engine and status bundle of stb_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface stb_sched_if #(
    parameter int REQ_COUNT     = 4,
    parameter int SMC_COUNT     = 6,
    parameter int BURST_WIDTH   = 8,
    parameter int ADDR_WIDTH    = 32,
    parameter int UR_ADDR_WIDTH = 11,
    parameter int UR_ID_WIDTH   = 3
);
    logic [REQ_COUNT-1:0]               req_valid;
    logic [REQ_COUNT-1:0]               req_ready;
    logic [REQ_COUNT*SMC_COUNT-1:0]     req_smc_strb;
    logic [REQ_COUNT*4-1:0]             req_byte_strb;
    logic [REQ_COUNT*BURST_WIDTH-1:0]   req_brst;
    logic [REQ_COUNT*ADDR_WIDTH-1:0]    req_gr_base_addr;
    logic [REQ_COUNT*UR_ID_WIDTH-1:0]   req_ur_id;
    logic [REQ_COUNT*UR_ADDR_WIDTH-1:0] req_ur_addr;

    logic                               stb_u_valid;
    logic [SMC_COUNT-1:0]               stb_u_smc_strb;
    logic [3:0]                         stb_u_byte_strb;
    logic [BURST_WIDTH-1:0]             stb_u_brst;
    logic [ADDR_WIDTH-1:0]              stb_u_gr_base_addr;
    logic [UR_ID_WIDTH-1:0]             stb_u_ur_id;
    logic [UR_ADDR_WIDTH-1:0]           stb_u_ur_addr;
    logic                               stb_d_valid;
    logic                               stb_d_done;

    logic [REQ_COUNT-1:0]               rsp_valid;
    logic                               rsp_err;
    logic                               busy;
    logic                               fault;

    // master: requesters and engine side; slave: the scheduler
    modport master (
        output req_valid, req_smc_strb, req_byte_strb, req_brst,
               req_gr_base_addr, req_ur_id, req_ur_addr,
               stb_d_valid, stb_d_done,
        input  req_ready, stb_u_valid, stb_u_smc_strb, stb_u_byte_strb,
               stb_u_brst, stb_u_gr_base_addr, stb_u_ur_id, stb_u_ur_addr,
               rsp_valid, rsp_err, busy, fault
    );

    modport slave (
        input  req_valid, req_smc_strb, req_byte_strb, req_brst,
               req_gr_base_addr, req_ur_id, req_ur_addr,
               stb_d_valid, stb_d_done,
        output req_ready, stb_u_valid, stb_u_smc_strb, stb_u_byte_strb,
               stb_u_brst, stb_u_gr_base_addr, stb_u_ur_id, stb_u_ur_addr,
               rsp_valid, rsp_err, busy, fault
    );
endinterface
`default_nettype wire

// File: rtl/stb_sched.sv
`default_nettype none
// ============================================================================
// Module      : stb_sched
// Description : Round-robin scheduler sharing one burst-store engine.
// Revision    : 1.0 - initial release
// ============================================================================
module stb_sched #(
    parameter int REQ_COUNT      = 4,
    parameter int SMC_COUNT      = 6,
    parameter int BURST_WIDTH    = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int UR_ADDR_WIDTH  = 11,
    parameter int UR_ID_WIDTH    = 3,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    stb_sched_if.slave bus
);
    localparam int PTR_W = $clog2(REQ_COUNT);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_RESP  = 3'd3,
        S_HALT  = 3'd4
    } state_e;

    state_e                   state_q, state_d;
    logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]         owner_q, owner_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err_q, err_d;
    logic                     tmo_q, tmo_d;
    logic [SMC_COUNT-1:0]     smc_q, smc_d;
    logic [3:0]               bstrb_q, bstrb_d;
    logic [BURST_WIDTH-1:0]   brst_q, brst_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [UR_ID_WIDTH-1:0]   urid_q, urid_d;
    logic [UR_ADDR_WIDTH-1:0] urad_q, urad_d;

    logic                     grant_vld;
    logic [PTR_W-1:0]         grant_idx;
    logic [PTR_W:0]           cand;
    logic [SMC_COUNT-1:0]     sel_smc;
    logic [3:0]               sel_bstrb;
    logic [BURST_WIDTH-1:0]   sel_brst;
    logic [ADDR_WIDTH-1:0]    sel_addr;
    logic [UR_ID_WIDTH-1:0]   sel_urid;
    logic [UR_ADDR_WIDTH-1:0] sel_urad;

    // First valid requester at or after rr_ptr, wrapping modulo REQ_COUNT
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < REQ_COUNT; k++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(REQ_COUNT)) begin
                cand = cand - (PTR_W+1)'(REQ_COUNT);
            end
            if (!grant_vld && bus.req_valid[cand[PTR_W-1:0]]) begin
                grant_vld = 1'b1;
                grant_idx = cand[PTR_W-1:0];
            end
        end
    end

    always_comb begin
        sel_smc   = '0;
        sel_bstrb = '0;
        sel_brst  = '0;
        sel_addr  = '0;
        sel_urid  = '0;
        sel_urad  = '0;
        for (int i = 0; i < REQ_COUNT; i++) begin
            if (grant_idx == PTR_W'(i)) begin
                sel_smc   = bus.req_smc_strb[i*SMC_COUNT +: SMC_COUNT];
                sel_bstrb = bus.req_byte_strb[i*4 +: 4];
                sel_brst  = bus.req_brst[i*BURST_WIDTH +: BURST_WIDTH];
                sel_addr  = bus.req_gr_base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_urid  = bus.req_ur_id[i*UR_ID_WIDTH +: UR_ID_WIDTH];
                sel_urad  = bus.req_ur_addr[i*UR_ADDR_WIDTH +: UR_ADDR_WIDTH];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        smc_d    = smc_q;
        bstrb_d  = bstrb_q;
        brst_d   = brst_q;
        addr_d   = addr_q;
        urid_d   = urid_q;
        urad_d   = urad_q;
        unique case (state_q)
            S_IDLE: begin
                if (grant_vld) begin
                    smc_d    = sel_smc;
                    bstrb_d  = sel_bstrb;
                    brst_d   = sel_brst;
                    addr_d   = sel_addr;
                    urid_d   = sel_urid;
                    urad_d   = sel_urad;
                    owner_d  = grant_idx;
                    rr_ptr_d = (grant_idx == PTR_W'(REQ_COUNT-1)) ? '0
                                                                   : grant_idx + PTR_W'(1);
                    err_d    = 1'b0;
                    tmo_d    = 1'b0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d = '0;
                // Zero-length bursts are rejected here, before the engine sees them
                if (brst_q == '0) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.stb_d_valid && bus.stb_d_done) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES-1)) begin
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                state_d = tmo_q ? S_HALT : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
            smc_q    <= '0;
            bstrb_q  <= '0;
            brst_q   <= '0;
            addr_q   <= '0;
            urid_q   <= '0;
            urad_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
            smc_q    <= smc_d;
            bstrb_q  <= bstrb_d;
            brst_q   <= brst_d;
            addr_q   <= addr_d;
            urid_q   <= urid_d;
            urad_q   <= urad_d;
        end
    end

    // Ready is gated by rst_n so every output reads zero while reset is held
    assign bus.req_ready = (rst_n && state_q == S_IDLE && grant_vld)
                         ? ({{(REQ_COUNT-1){1'b0}}, 1'b1} << grant_idx) : '0;
    assign bus.stb_u_valid        = (state_q == S_ISSUE) && (brst_q != '0);
    assign bus.stb_u_smc_strb     = smc_q;
    assign bus.stb_u_byte_strb    = bstrb_q;
    assign bus.stb_u_brst         = brst_q;
    assign bus.stb_u_gr_base_addr = addr_q;
    assign bus.stb_u_ur_id        = urid_q;
    assign bus.stb_u_ur_addr      = urad_q;
    assign bus.rsp_valid = (state_q == S_RESP)
                         ? ({{(REQ_COUNT-1){1'b0}}, 1'b1} << owner_q) : '0;
    assign bus.rsp_err   = (state_q == S_RESP) && err_q;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.fault     = (state_q == S_HALT);

endmodule
`default_nettype wire

// File: tb/tb_stb_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_stb_sched
// Description : Randomized self-checking bench for stb_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stb_sched;
    localparam int REQ = 4;
    localparam int SMC = 6;
    localparam int BW  = 8;
    localparam int AW  = 32;
    localparam int URW = 11;
    localparam int IDW = 3;
    localparam int TMO = 64;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;

    stb_sched_if #(
        .REQ_COUNT(REQ), .SMC_COUNT(SMC), .BURST_WIDTH(BW),
        .ADDR_WIDTH(AW), .UR_ADDR_WIDTH(URW), .UR_ID_WIDTH(IDW)
    ) bus ();

    stb_sched #(
        .REQ_COUNT(REQ), .SMC_COUNT(SMC), .BURST_WIDTH(BW), .ADDR_WIDTH(AW),
        .UR_ADDR_WIDTH(URW), .UR_ID_WIDTH(IDW), .TIMEOUT_CYCLES(TMO)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Per-requester command fields and bench-side scheduling state
    logic [SMC-1:0] a_smc  [REQ];
    logic [3:0]     a_bs   [REQ];
    logic [BW-1:0]  a_brst [REQ];
    logic [AW-1:0]  a_addr [REQ];
    logic [IDW-1:0] a_id   [REQ];
    logic [URW-1:0] a_ur   [REQ];
    logic [REQ-1:0] mask;
    logic [REQ-1:0] last_ready;
    int             exp_ptr;
    int             last_rsp_cyc;

    task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [REQ-1:0] onehot(input int g);
        logic [REQ-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input logic [REQ-1:0] m, input int p);
        for (int k = 0; k < REQ; k++) begin
            if (m[(p + k) % REQ]) return (p + k) % REQ;
        end
        return 0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_fields();
        for (int i = 0; i < REQ; i++) begin
            bus.req_smc_strb[i*SMC +: SMC]    = a_smc[i];
            bus.req_byte_strb[i*4 +: 4]       = a_bs[i];
            bus.req_brst[i*BW +: BW]          = a_brst[i];
            bus.req_gr_base_addr[i*AW +: AW]  = a_addr[i];
            bus.req_ur_id[i*IDW +: IDW]       = a_id[i];
            bus.req_ur_addr[i*URW +: URW]     = a_ur[i];
        end
        bus.req_valid = mask;
    endtask

    task automatic rand_fields(input bit allow_zero);
        for (int i = 0; i < REQ; i++) begin
            a_smc[i]  = ($urandom_range(0, 5) == 0) ? '0 : SMC'($urandom);
            a_bs[i]   = 4'($urandom);
            a_brst[i] = (allow_zero && $urandom_range(0, 5) == 0) ? '0
                                                                   : BW'($urandom_range(1, 255));
            a_addr[i] = $urandom;
            a_id[i]   = IDW'($urandom);
            a_ur[i]   = URW'($urandom);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mask  = '0;
        bus.stb_d_valid = 1'b0;
        bus.stb_d_done  = 1'b0;
        drive_fields();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        exp_ptr = 0;
    endtask

    // One command from an IDLE cycle; lat = WAIT cycle carrying completion
    // (lat >= TMO means the engine never answers). Ends in the cycle after RESP.
    task automatic run_cmd(input int lat, input bit hold);
        int g;
        bit hit;
        #1;
        g = pick(mask, exp_ptr);
        last_ready = bus.req_ready;
        chk_eq("req_ready", bus.req_ready, onehot(g));
        chk_eq("busy_idle", bus.busy, 0);
        exp_ptr = (g + 1) % REQ;
        step();
        if (!hold) begin
            mask = '0;
            bus.req_valid = '0;
        end
        chk_eq("u_valid", bus.stb_u_valid, a_brst[g] != 0);
        chk_eq("u_smc", bus.stb_u_smc_strb, a_smc[g]);
        chk_eq("u_bs", bus.stb_u_byte_strb, a_bs[g]);
        chk_eq("u_brst", bus.stb_u_brst, a_brst[g]);
        chk_eq("u_addr", bus.stb_u_gr_base_addr, a_addr[g]);
        chk_eq("u_id", bus.stb_u_ur_id, a_id[g]);
        chk_eq("u_ur", bus.stb_u_ur_addr, a_ur[g]);
        if (a_brst[g] == 0) begin
            step();
            chk_eq("rsp_valid_rej", bus.rsp_valid, onehot(g));
            chk_eq("rsp_err_rej", bus.rsp_err, 1);
            last_rsp_cyc = cyc;
            step();
            chk_eq("busy_after_rej", bus.busy, 0);
            return;
        end
        if (hold && last_rsp_cyc >= 0) chk_eq("issue_gap", cyc - last_rsp_cyc, 2);
        hit = 1'b0;
        for (int w = 0; w < TMO; w++) begin
            step();
            chk_eq("wait_quiet", {bus.stb_u_valid, bus.rsp_valid}, 0);
            if (w == lat) begin
                bus.stb_d_valid = 1'b1;
                bus.stb_d_done  = 1'b1;
                hit = 1'b1;
            end else begin
                bus.stb_d_valid = ($urandom_range(0, 3) == 0);
                bus.stb_d_done  = 1'b0;
            end
            if (hit) break;
        end
        step();
        bus.stb_d_valid = ($urandom_range(0, 1) == 1);
        bus.stb_d_done  = 1'b1;
        chk_eq("rsp_valid", bus.rsp_valid, onehot(g));
        chk_eq("rsp_err", bus.rsp_err, !hit);
        last_rsp_cyc = cyc;
        step();
        bus.stb_d_valid = 1'b0;
        bus.stb_d_done  = 1'b0;
        chk_eq("fault_after", bus.fault, !hit);
        chk_eq("busy_after", bus.busy, !hit);
    endtask

    // Idle cycle with a stray engine response that must be ignored
    task automatic idle_gap();
        bus.stb_d_valid = 1'b1;
        bus.stb_d_done  = 1'b1;
        #1;
        chk_eq("idle_ready", bus.req_ready, 0);
        step();
        bus.stb_d_valid = 1'b0;
        bus.stb_d_done  = 1'b0;
        chk_eq("idle_stays", {bus.busy, bus.rsp_valid, bus.stb_u_valid}, 0);
    endtask

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};
        n_chk = 0;
        n_fail = 0;
        last_rsp_cyc = -1;
        rand_fields(1'b0);
        rst_n = 1'b0;
        mask  = '0;
        bus.stb_d_valid = 1'b0;
        bus.stb_d_done  = 1'b0;
        drive_fields();
        #1;
        chk_eq("rst_outs", {bus.req_ready, bus.stb_u_valid, bus.rsp_valid, bus.rsp_err,
                            bus.busy, bus.fault}, 0);
        chk_eq("rst_fields", {bus.stb_u_smc_strb, bus.stb_u_byte_strb, bus.stb_u_brst,
                              bus.stb_u_gr_base_addr, bus.stb_u_ur_id, bus.stb_u_ur_addr}, 0);
        do_reset();

        // Single request on requester 2, engine answers after 40 cycles
        a_brst[2] = 8'd4;
        a_addr[2] = 32'h1000;
        a_ur[2]   = 11'h10;
        a_id[2]   = 3'd5;
        mask = 4'b0100;
        drive_fields();
        run_cmd(39, 1'b0);
        idle_gap();

        // All requesters held valid from reset
        do_reset();
        rand_fields(1'b0);
        mask = 4'b1111;
        drive_fields();
        last_rsp_cyc = -1;
        for (int n = 0; n < 5; n++) begin
            run_cmd($urandom_range(0, 10), 1'b1);
            chk_eq("rr_order", last_ready, onehot(order[n]));
        end
        mask = '0;
        bus.req_valid = '0;
        idle_gap();

        // Zero-length burst on requester 1, then requester 2 served normally
        rand_fields(1'b0);
        a_brst[1] = '0;
        mask = 4'b0010;
        drive_fields();
        run_cmd(5, 1'b0);
        mask = 4'b0100;
        drive_fields();
        run_cmd(3, 1'b0);
        idle_gap();

        // Completion on the terminal timeout cycle wins
        rand_fields(1'b0);
        mask = 4'b1000;
        drive_fields();
        run_cmd(TMO - 1, 1'b0);
        idle_gap();

        // Engine never answers: timeout, then halt until reset
        rand_fields(1'b0);
        mask = 4'b0001;
        drive_fields();
        run_cmd(TMO + 8, 1'b0);
        mask = 4'b1111;
        bus.req_valid = mask;
        for (int n = 0; n < 3; n++) begin
            #1;
            chk_eq("halt_outs", {bus.fault, bus.req_ready, bus.stb_u_valid, bus.rsp_valid},
                   {1'b1, 4'b0000, 1'b0, 4'b0000});
            step();
        end
        rst_n = 1'b0;
        #1;
        chk_eq("halt_rst_fault", bus.fault, 0);
        step();
        rst_n = 1'b0;
        do_reset();

        // Reset in the middle of WAIT aborts without a response
        rand_fields(1'b0);
        mask = 4'b1000;
        drive_fields();
        #1;
        step();
        step();
        step();
        mask = 4'b1111;
        bus.req_valid = mask;
        rst_n = 1'b0;
        #1;
        chk_eq("rst_wait_outs", {bus.req_ready, bus.stb_u_valid, bus.rsp_valid, bus.rsp_err,
                                 bus.busy, bus.fault}, 0);
        for (int n = 0; n < 3; n++) begin
            step();
            chk_eq("rst_no_rsp", bus.rsp_valid, 0);
        end
        rst_n = 1'b1;
        exp_ptr = 0;
        run_cmd(2, 1'b0);
        idle_gap();

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            rand_fields(1'b1);
            mask = REQ'($urandom_range(1, (1 << REQ) - 1));
            drive_fields();
            run_cmd(($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 20), 1'b0);
            idle_gap();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "bench watchdog expired");
    end
endmodule
`default_nettype wire
